bip_control: RTL and testbench

//  Control unit for the BIP accumulator datapath: fetches 16-bit instructions from a sync ROM,

---
 rtl/bip_control.sv | 173 +++++++++++++++++
 tb/tb_bip_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// BIP control unit: fetches 16-bit instructions from a synchronous ROM, decodes them and
// drives the accumulator-datapath and data-RAM strobes from state + opcode.
module bip_control #(
  parameter int PC_WIDTH      = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start,
  output logic [PC_WIDTH-1:0]      Instr_Addr,
  input  logic [15:0]              Instr_Data,
  output logic [OPERAND_WIDTH-1:0] Operand,
  output logic [1:0]               SelA,
  output logic                     SelB,
  output logic                     Op,
  output logic                     WrAcc,
  output logic                     WrRam,
  output logic                     RdRam,
  output logic                     Busy,
  output logic                     Halted,
  output logic [COUNT_WIDTH-1:0]   Clk_Count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

  localparam logic [PC_WIDTH-1:0]    PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [15:0]              ir_q, ir_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [OPCODE_WIDTH-1:0]  opcode_s;
  logic [OPERAND_WIDTH-1:0] operand_s;
  logic                     busy_s;

  // In DECODE the ROM word is still on Instr_Data and has not yet reached IR.
  always_comb begin
    if (state_q == S_DECODE) begin
      opcode_s  = Instr_Data[15 -: OPCODE_WIDTH];
      operand_s = Instr_Data[OPERAND_WIDTH-1:0];
    end else begin
      opcode_s  = ir_q[15 -: OPCODE_WIDTH];
      operand_s = ir_q[OPERAND_WIDTH-1:0];
    end
  end

  assign busy_s = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_MEM);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    if (busy_s && (cnt_q != COUNT_MAX)) begin
      cnt_d = cnt_q + COUNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = Instr_Data;
        case (opcode_s)
          OP_HLT:                state_d = S_HALT;
          OP_LD, OP_ADD, OP_SUB: state_d = S_MEM;
          default: begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        pc_d    = pc_q + PC_ONE;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are forced low while reset is high so a MEM-cycle accumulator write is dropped.
  always_comb begin
    SelA  = 2'd0;
    SelB  = 1'b0;
    Op    = 1'b0;
    WrAcc = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (!reset) begin
      case (state_q)
        S_DECODE: begin
          case (opcode_s)
            OP_STO: WrRam = 1'b1;
            OP_LDI: begin
              SelA  = 2'd1;
              WrAcc = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
              SelA  = 2'd2;
              SelB  = 1'b1;
              Op    = (opcode_s == OP_SUBI);
              WrAcc = 1'b1;
            end
            OP_LD, OP_ADD, OP_SUB: RdRam = 1'b1;
            default: WrAcc = 1'b0;
          endcase
        end
        S_MEM: begin
          case (opcode_s)
            OP_LD: WrAcc = 1'b1;
            OP_ADD, OP_SUB: begin
              SelA  = 2'd2;
              Op    = (opcode_s == OP_SUB);
              WrAcc = 1'b1;
            end
            default: WrAcc = 1'b0;
          endcase
        end
        default: WrAcc = 1'b0;
      endcase
    end else begin
      WrAcc = 1'b0;
    end
  end

  assign Instr_Addr = pc_q;
  assign Operand    = operand_s;
  assign Busy       = busy_s;
  assign Halted     = (state_q == S_HALT);
  assign Clk_Count  = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control with a sync ROM, data RAM and accumulator datapath model.
module tb_bip_control;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [10:0] Instr_Addr;
  logic [15:0] Instr_Data;
  logic [10:0] Operand;
  logic [1:0]  SelA;
  logic        SelB, Op, WrAcc, WrRam, RdRam, Busy, Halted;
  logic [15:0] Clk_Count;

  logic [15:0] rom [0:2047];
  logic [15:0] ram [0:2047];
  logic [15:0] acc = 16'h0000;
  logic [15:0] out_data;
  logic        ld_en;
  logic [10:0] ld_addr;
  logic [15:0] ld_val;
  logic [6:0]  strb;
  logic [15:0] sext_s, alu_b_s;

  int total = 0;
  int bad   = 0;

  bip_control dut (
    .clk(clk), .reset(reset), .Start(Start),
    .Instr_Addr(Instr_Addr), .Instr_Data(Instr_Data), .Operand(Operand),
    .SelA(SelA), .SelB(SelB), .Op(Op), .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam),
    .Busy(Busy), .Halted(Halted), .Clk_Count(Clk_Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign strb    = {SelA, SelB, Op, WrAcc, WrRam, RdRam};
  assign sext_s  = {{5{Operand[10]}}, Operand};
  assign alu_b_s = SelB ? sext_s : out_data;

  always @(posedge clk) begin
    Instr_Data <= rom[Instr_Addr];
  end

  // Accumulator datapath and data RAM driven by the control strobes.
  always @(posedge clk) begin
    if (RdRam) out_data <= ram[Operand];
    if (WrRam) ram[Operand] <= acc;
    if (ld_en) ram[ld_addr] <= ld_val;
    if (WrAcc) begin
      case (SelA)
        2'd0:    acc <= out_data;
        2'd1:    acc <= sext_s;
        default: acc <= Op ? (acc - alu_b_s) : (acc + alu_b_s);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) rom[i] = w;
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; ld_en = 1'b0; ld_addr = 11'd0; ld_val = 16'h0000;
    fill_rom(16'h0000);

    // 1: LDI 5
    rom[0] = 16'h1805;
    do_reset();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_halted", Halted, 1'b0);
    chk("rst_pc", Instr_Addr, 11'd0);
    chk("rst_count", Clk_Count, 16'd0);
    chk("rst_strb", strb, 7'b0000000);
    tick();
    chk("idle_wait", Busy, 1'b0);
    pulse_start();
    chk("t1_fetch_busy", Busy, 1'b1);
    chk("t1_fetch_strb", strb, 7'b0000000);
    tick();
    chk("t1_ldi_strb", strb, 7'b0100100);
    chk("t1_ldi_operand", Operand, 11'd5);
    tick();
    chk("t1_pc1", Instr_Addr, 11'd1);
    chk("t1_acc", acc, 16'd5);
    tick();
    tick();
    chk("t1_halted", Halted, 1'b1);
    chk("t1_count", Clk_Count, 16'd4);

    // 2: LDI 3, ADDI 4, SUBI 2, HLT
    fill_rom(16'h0000);
    rom[0] = 16'h1803; rom[1] = 16'h2804; rom[2] = 16'h3802;
    do_reset();
    pulse_start();
    tick();
    chk("t2_ldi_strb", strb, 7'b0100100);
    tick();
    chk("t2_acc3", acc, 16'd3);
    tick();
    chk("t2_addi_strb", strb, 7'b1010100);
    tick();
    chk("t2_acc7", acc, 16'd7);
    tick();
    chk("t2_subi_strb", strb, 7'b1011100);
    tick();
    chk("t2_acc5", acc, 16'd5);
    tick();
    chk("t2_hlt_strb", strb, 7'b0000000);
    chk("t2_count_hlt_decode", Clk_Count, 16'd7);
    tick();
    chk("t2_halted", Halted, 1'b1);
    chk("t2_busy", Busy, 1'b0);
    chk("t2_count", Clk_Count, 16'd8);
    chk("t2_pc", Instr_Addr, 11'd3);
    pulse_start();
    tick();
    chk("t2_start_ignored", Halted, 1'b1);
    chk("t2_count_held", Clk_Count, 16'd8);
    chk("t2_pc_held", Instr_Addr, 11'd3);

    // 3: LD 10, ADD 10, STO 11 with RAM[10]=9
    fill_rom(16'h0000);
    rom[0] = 16'h100A; rom[1] = 16'h200A; rom[2] = 16'h080B;
    do_reset();
    ld_en = 1'b1; ld_addr = 11'd10; ld_val = 16'h0009;
    tick();
    ld_en = 1'b0;
    pulse_start();
    tick();
    chk("t3_ld_dec_strb", strb, 7'b0000001);
    chk("t3_ld_operand", Operand, 11'd10);
    tick();
    chk("t3_ld_mem_strb", strb, 7'b0000100);
    chk("t3_ld_mem_operand", Operand, 11'd10);
    chk("t3_ld_pc_held", Instr_Addr, 11'd0);
    tick();
    chk("t3_acc9", acc, 16'd9);
    chk("t3_pc1", Instr_Addr, 11'd1);
    tick();
    chk("t3_add_dec_strb", strb, 7'b0000001);
    tick();
    chk("t3_add_mem_strb", strb, 7'b1000100);
    tick();
    chk("t3_acc18", acc, 16'h0012);
    tick();
    chk("t3_sto_strb", strb, 7'b0000010);
    chk("t3_sto_operand", Operand, 11'd11);
    tick();
    chk("t3_ram11", ram[11], 16'h0012);
    tick();
    tick();
    chk("t3_halted", Halted, 1'b1);
    chk("t3_count", Clk_Count, 16'd10);

    // 4: undefined opcode 0x1F is a NOP
    fill_rom(16'h0000);
    rom[0] = 16'hF800;
    do_reset();
    pulse_start();
    tick();
    chk("t4_nop_strb", strb, 7'b0000000);
    chk("t4_nop_busy", Busy, 1'b1);
    tick();
    chk("t4_pc1", Instr_Addr, 11'd1);
    tick();
    chk("t4_not_yet_halted", Halted, 1'b0);
    tick();
    chk("t4_halted", Halted, 1'b1);
    chk("t4_count", Clk_Count, 16'd4);

    // 5: PC wrap and counter saturation on a NOP-filled ROM
    fill_rom(16'hF800);
    do_reset();
    pulse_start();
    for (int i = 0; i < 2 * 2047; i++) tick();
    chk("t5_pc_max", Instr_Addr, 11'h7FF);
    tick();
    tick();
    chk("t5_pc_wrap", Instr_Addr, 11'h000);
    chk("t5_count_4096", Clk_Count, 16'd4096);
    for (int i = 0; i < 61438; i++) tick();
    chk("t5_count_fffe", Clk_Count, 16'hFFFE);
    tick();
    chk("t5_count_ffff", Clk_Count, 16'hFFFF);
    tick();
    tick();
    chk("t5_count_sat", Clk_Count, 16'hFFFF);
    chk("t5_busy", Busy, 1'b1);

    // 6: reset in MEM of ADD drops the accumulator write
    fill_rom(16'h0000);
    rom[0] = 16'h1805; rom[1] = 16'h200A;
    do_reset();
    pulse_start();
    tick();
    tick();
    tick();
    tick();
    chk("t6_mem_strb", strb, 7'b1000100);
    reset = 1'b1;
    Start = 1'b1;
    #1;
    chk("t6_wracc_dropped", WrAcc, 1'b0);
    chk("t6_strb_dropped", strb, 7'b0000000);
    tick();
    chk("t6_idle", Busy, 1'b0);
    chk("t6_pc0", Instr_Addr, 11'd0);
    chk("t6_count0", Clk_Count, 16'd0);
    chk("t6_acc_kept", acc, 16'd5);
    tick();
    chk("t6_reset_start_idle", Busy, 1'b0);
    reset = 1'b0;
    Start = 1'b0;
    tick();
    chk("t6_needs_new_start", Busy, 1'b0);
    pulse_start();
    chk("t6_restart", Busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
